piso_tx_scheduler: RTL

- Round-robin scheduler that shares one parallel-in/serial-out shift register among NUM_REQ requesters.
- Each requester offers a WIDTH-bit word with a valid/ready handshake.
- The block grants one requester, loads its word, shifts it out MSB-first with first/last framing, inserts a programmable inter-frame gap, then re-arbitrates.
- Sits between the parallel producers and the serial link.

---
 rtl/piso_pkg.sv | 25 ++
 rtl/piso_shift_core.sv | 34 +++
 rtl/piso_tx_scheduler.sv | 133 +++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | piso_pkg : shared state encoding, defaults and width helper for PISO TX  |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
package piso_pkg;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_SHIFT = 2'd1;
  localparam logic [1:0] c_ST_GAP   = 2'd2;

  localparam int c_DEF_WIDTH   = 4;
  localparam int c_DEF_NUM_REQ = 2;
  localparam int c_DEF_GAP     = 1;

  // Bits needed to encode values 0..n-1, never less than one.
  function automatic int piso_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso_shift_core.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | piso_shift_core : WIDTH-bit load/shift-left register, MSB presented out  |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module piso_shift_core
  import piso_pkg::*;
#(
  parameter int WIDTH = c_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_dout
);

  logic [WIDTH-1:0] r_sreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg <= '0;
    end else if (i_load) begin
      r_sreg <= i_din;
    end else if (i_shift) begin
      r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
    end
  end

  assign o_dout = r_sreg[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/piso_tx_scheduler.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | piso_tx_scheduler : round-robin arbiter feeding one framed PISO link     |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module piso_tx_scheduler
  import piso_pkg::*;
#(
  parameter int WIDTH   = c_DEF_WIDTH,
  parameter int NUM_REQ = c_DEF_NUM_REQ,
  parameter int GAP     = c_DEF_GAP
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 i_req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]           i_req_data,
  output logic [NUM_REQ-1:0]                 o_req_ready,
  output logic                               o_ser_out,
  output logic                               o_ser_valid,
  output logic                               o_ser_first,
  output logic                               o_ser_last,
  output logic [piso_width(NUM_REQ)-1:0]     o_grant_id,
  output logic                               o_busy
);

  localparam int IDW = piso_width(NUM_REQ);
  localparam int CW  = piso_width(WIDTH);
  localparam int GW  = piso_width(GAP + 1);

  localparam logic [CW-1:0]  c_CNT_TOP  = CW'(WIDTH - 1);
  localparam logic [GW-1:0]  c_GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [IDW-1:0] c_PTR_RST  = IDW'(NUM_REQ - 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_bit_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic [IDW-1:0]   r_grant_id;
  logic [IDW-1:0]   r_last_grant;

  logic             w_any;
  logic             w_found;
  logic [IDW-1:0]   w_winner;
  int               w_idx;
  logic             w_transfer;
  logic             w_in_shift;
  logic [WIDTH-1:0] w_din;
  logic             w_dout;

  // Search starts just past the previous owner so every requester gets a turn.
  always_comb begin
    w_any    = |i_req_valid;
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = (int'(r_last_grant) + k) % NUM_REQ;
      if (!w_found && i_req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = IDW'(w_idx);
      end
    end
  end

  assign w_transfer = (r_state == c_ST_IDLE) && w_any;
  assign w_in_shift = (r_state == c_ST_SHIFT);

  always_comb begin
    o_req_ready = '0;
    if (w_transfer) o_req_ready[w_winner] = 1'b1;
  end

  always_comb begin
    w_din = i_req_data[int'(w_winner)*WIDTH +: WIDTH];
  end

  piso_shift_core #(
    .WIDTH (WIDTH)
  ) u_shift_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_transfer),
    .i_shift (w_in_shift),
    .i_din   (w_din),
    .o_dout  (w_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_ST_IDLE;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_grant_id   <= '0;
      r_last_grant <= c_PTR_RST;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_transfer) begin
            r_state      <= c_ST_SHIFT;
            r_bit_cnt    <= c_CNT_TOP;
            r_grant_id   <= w_winner;
            r_last_grant <= w_winner;
          end
        end
        c_ST_SHIFT: begin
          if (r_bit_cnt == '0) begin
            r_state   <= (GAP > 0) ? c_ST_GAP : c_ST_IDLE;
            r_gap_cnt <= '0;
          end else begin
            r_bit_cnt <= r_bit_cnt - CW'(1);
          end
        end
        c_ST_GAP: begin
          if (r_gap_cnt == c_GAP_LAST) begin
            r_state <= c_ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  // Serial outputs decode registers only, so reset clears them without a clock.
  assign o_ser_valid = w_in_shift;
  assign o_ser_out   = w_in_shift & w_dout;
  assign o_ser_first = w_in_shift && (r_bit_cnt == c_CNT_TOP);
  assign o_ser_last  = w_in_shift && (r_bit_cnt == '0);
  assign o_grant_id  = r_grant_id;
  assign o_busy      = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire
